// File: rtl/fifo_2p_ram_prefetch.sv
// Deep show-ahead FIFO: inferred 2-port RAM with a LATENCY-stage read pipeline feeding a
// small register prefetch buffer, plus occupancy count, runtime almost flags and sync clear.
module fifo_2p_ram_prefetch #(
   parameter int DATA_WIDTH   = 8,
   parameter int RAM_DEPTH    = 256,
   parameter int LATENCY      = 3,
   parameter int BUFFER_DEPTH = 8,
   localparam int CNT_W       = $clog2(RAM_DEPTH + BUFFER_DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic [CNT_W-1:0]      almost_full_thresh,
   input  logic [CNT_W-1:0]      almost_empty_thresh,
   output logic [CNT_W-1:0]      count,
   output logic                  almost_full,
   output logic                  almost_empty
);

   localparam int AW = $clog2(RAM_DEPTH);
   localparam int BW = $clog2(BUFFER_DEPTH);
   localparam int OW = BW + 2;
   localparam logic [CNT_W-1:0] CAP = CNT_W'(RAM_DEPTH + BUFFER_DEPTH);

   // Handshake: a transfer happens on a rising edge where valid & ready are both high
   // (and clear is low); valid never waits on ready, and rd_data holds while stalled.

   logic [DATA_WIDTH-1:0] ram [RAM_DEPTH];
   logic [DATA_WIDTH-1:0] pipe [LATENCY];
   logic [DATA_WIDTH-1:0] buf_mem [BUFFER_DEPTH];
   logic [AW:0]           wr_ptr, rd_ptr;
   logic [BW:0]           buf_wp, buf_rp;
   logic [LATENCY-1:0]    tag;
   logic [OW-1:0]         inflight, occ;
   logic [CNT_W-1:0]      count_next;
   logic                  wr_fire, rd_fire, ram_empty, credit, bypass, ram_wr, issue, buf_exit;

   assign rd_valid  = (buf_wp != buf_rp);
   assign rd_data   = buf_mem[buf_rp[BW-1:0]];
   assign wr_fire   = wr_valid & wr_ready & ~clear;
   assign rd_fire   = rd_valid & rd_ready & ~clear;
   assign ram_empty = (wr_ptr == rd_ptr);
   assign occ       = OW'(buf_wp - buf_rp) + inflight;

   // Buffer slots are reserved at issue time, so a draining read frees one this cycle.
   assign credit   = (occ < OW'(BUFFER_DEPTH)) | rd_fire;
   assign bypass   = wr_fire & ram_empty & (inflight == '0) & credit;
   assign ram_wr   = wr_fire & ~bypass;
   assign issue    = ~ram_empty & credit & ~clear;
   assign buf_exit = tag[LATENCY-1] & ~clear;

   always_comb begin
      count_next = count;
      case ({wr_fire, rd_fire})
         2'b10:   count_next = count + CNT_W'(1);
         2'b01:   count_next = count - CNT_W'(1);
         default: count_next = count;
      endcase
   end

   assign almost_full  = (count >= almost_full_thresh);
   assign almost_empty = (count <= almost_empty_thresh);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count    <= '0;
         wr_ready <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         buf_wp   <= '0;
         buf_rp   <= '0;
         tag      <= '0;
         inflight <= '0;
      end else if (clear) begin
         count    <= '0;
         wr_ready <= 1'b1;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         buf_wp   <= '0;
         buf_rp   <= '0;
         tag      <= '0;
         inflight <= '0;
      end else begin
         count    <= count_next;
         wr_ready <= (count_next < CAP);
         if (ram_wr) wr_ptr <= wr_ptr + 1'b1;
         if (issue) rd_ptr <= rd_ptr + 1'b1;
         tag[0] <= issue;
         for (int i = 1; i < LATENCY; i++) tag[i] <= tag[i-1];
         inflight <= inflight + OW'(issue) - OW'(buf_exit);
         if (bypass | buf_exit) buf_wp <= buf_wp + 1'b1;
         if (rd_fire) buf_rp <= buf_rp + 1'b1;
      end
   end

   // RAM array and read pipeline carry no reset; the tag bits say what is live.
   always_ff @(posedge clk) begin
      if (ram_wr) ram[wr_ptr[AW-1:0]] <= wr_data;
      if (issue) pipe[0] <= ram[rd_ptr[AW-1:0]];
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
   end

   always_ff @(posedge clk) begin
      if (bypass)
         buf_mem[buf_wp[BW-1:0]] <= wr_data;
      else if (buf_exit)
         buf_mem[buf_wp[BW-1:0]] <= pipe[LATENCY-1];
   end

endmodule

// File: tb/tb_fifo_2p_ram_prefetch.sv
// Bench for fifo_2p_ram_prefetch: cycle driver, expected-data queue and count model,
// directed cases (bypass, full fill, streaming, clear with reads in flight) then random traffic.
module tb_fifo_2p_ram_prefetch;

   localparam int DW    = 8;
   localparam int RD    = 256;
   localparam int LAT   = 3;
   localparam int BD    = 8;
   localparam int CNT_W = $clog2(RD + BD) + 1;
   localparam int CAP   = RD + BD;
   localparam int AF    = 260;
   localparam int AE    = 2;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             clear = 1'b0;
   logic             wr_valid = 1'b0;
   logic             rd_ready = 1'b0;
   logic [DW-1:0]    wr_data = '0;
   logic [CNT_W-1:0] af_th = CNT_W'(AF);
   logic [CNT_W-1:0] ae_th = CNT_W'(AE);
   logic             wr_ready, rd_valid, almost_full, almost_empty;
   logic [DW-1:0]    rd_data;
   logic [CNT_W-1:0] count;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [DW-1:0] exp_q[$];
   int            m_cnt = 0;
   logic          m_wr_ready = 1'b0;
   logic          last_wf, last_rv;
   int            last_pre_cnt;
   int            sent;

   fifo_2p_ram_prefetch #(
      .DATA_WIDTH(DW), .RAM_DEPTH(RD), .LATENCY(LAT), .BUFFER_DEPTH(BD)
   ) dut (
      .clk(clk), .reset_n(reset_n), .clear(clear),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .almost_full_thresh(af_th), .almost_empty_thresh(ae_th),
      .count(count), .almost_full(almost_full), .almost_empty(almost_empty)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reset ----------------
   task automatic do_reset();
      @(negedge clk);
      #3;
      reset_n  = 1'b0;
      wr_valid = 1'b0;
      rd_ready = 1'b0;
      clear    = 1'b0;
      #1;
      check("rst_count", count, 0);
      check("rst_wr_ready", wr_ready, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_almost_empty", almost_empty, 1);
      check("rst_almost_full", almost_full, 0);
      repeat (2) @(negedge clk);
      check("rst_hold_wr_ready", wr_ready, 0);
      reset_n = 1'b1;
      exp_q.delete();
      m_cnt      = 0;
      m_wr_ready = 1'b1;
   endtask

   // ---------------- driver + scoreboard ----------------
   task automatic step(input logic wv, input logic [DW-1:0] wd, input logic rr, input logic clr);
      logic wf, rf;
      @(negedge clk);
      wr_valid = wv;
      wr_data  = wd;
      rd_ready = rr;
      clear    = clr;
      #1;
      check("count", count, m_cnt);
      check("wr_ready", wr_ready, m_wr_ready);
      check("almost_full", almost_full, m_cnt >= AF);
      check("almost_empty", almost_empty, m_cnt <= AE);
      if (m_cnt == 0) check("rd_valid_empty", rd_valid, 0);
      wf = wv & wr_ready & ~clr;
      rf = rd_valid & rr & ~clr;
      last_pre_cnt = m_cnt;
      last_rv      = rd_valid;
      last_wf      = wf;
      if (rf && exp_q.size() > 0) check("rd_data", rd_data, exp_q.pop_front());
      if (wf) exp_q.push_back(wd);
      if (clr) exp_q.delete();
      m_cnt      = exp_q.size();
      m_wr_ready = (m_cnt < CAP);
   endtask

   task automatic fill(input int n, input int budget);
      sent = 0;
      for (int k = 0; k < budget && sent < n; k++) begin
         step(1'b1, DW'(sent), 1'b0, 1'b0);
         if (last_wf) sent++;
      end
      check("fill_sent", sent, n);
   endtask

   task automatic drain(input int budget);
      for (int k = 0; k < budget && exp_q.size() > 0; k++) step(1'b0, '0, 1'b1, 1'b0);
      check("drain_done", exp_q.size(), 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      do_reset();

      // single write takes the bypass path
      step(1'b1, 8'hA5, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      check("t1_rd_valid", rd_valid, 1);
      check("t1_rd_data", rd_data, 8'hA5);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      check("t1_count_zero", count, 0);

      // fill to capacity, then one rejected write, then drain in order
      fill(CAP, 400);
      step(1'b1, 8'hFF, 1'b0, 1'b0);
      check("t2_full_reject", last_wf, 0);
      check("t2_full_count", count, CAP);
      drain(2000);

      // buffer full plus RAM backlog, then continuous streaming with no bubbles
      fill(BD + 10, 100);
      repeat (4) step(1'b0, '0, 1'b0, 1'b0);
      for (int k = 0; k < 100 && m_cnt > 0; k++) begin
         step(1'b0, '0, 1'b1, 1'b0);
         if (last_pre_cnt > 0) check("t3_no_gap", last_rv, 1);
      end
      check("t3_drained", m_cnt, 0);

      // clear while three RAM reads are in flight
      fill(BD + 5, 100);
      repeat (3) step(1'b0, '0, 1'b1, 1'b0);
      step(1'b1, 8'h77, 1'b1, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0);
      check("t5_clear_rd_valid", rd_valid, 0);
      check("t5_clear_count", count, 0);
      step(1'b1, 8'h11, 1'b0, 1'b0);
      repeat (8) step(1'b0, '0, 1'b0, 1'b0);
      check("t5_new_count", count, 1);
      check("t5_new_data", rd_data, 8'h11);
      drain(50);
      repeat (8) step(1'b0, '0, 1'b1, 1'b0);

      // random traffic, 50/50
      for (int k = 0; k < 10000; k++)
         step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), 1'b0);

      // biased fill/drain rounds to wrap the RAM pointers many times
      for (int r = 0; r < 22; r++) begin
         for (int k = 0; k < 3000 && m_cnt < CAP; k++)
            step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 3) == 0, 1'b0);
         check("t6_reached_full", m_cnt, CAP);
         for (int k = 0; k < 3000 && m_cnt > 0; k++)
            step($urandom_range(0, 3) == 0, DW'($urandom), $urandom_range(0, 3) != 0, 1'b0);
         check("t6_reached_empty", m_cnt, 0);
      end

      // asynchronous reset in the middle of traffic
      fill(40, 100);
      do_reset();
      step(1'b1, 8'h3C, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      check("t7_after_reset_data", rd_data, 8'h3C);
      drain(20);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
